pipe_mem_arbiter: RTL and testbench

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

---
 rtl/pipe_mem_arbiter_if.sv | 36 +++
 rtl/pipe_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the single-port memory.
// The slave modport is the arbiter's view. The master modport is the view of
// everything around it: the fetch and memory stages, and the memory itself.
interface pipe_mem_arbiter_if;
    // Fetch-stage port.
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    // Memory-stage (data) port.
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    // Single-port memory bus.
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbiter that shares one single-port memory between the fetch and data stages.
// Only one access is in flight at a time. The m_* bus is registered at the grant
// and held until m_ack. Each completion produces a one-cycle ready pulse on the
// port that owned the access.
// Optional macro PIPE_ARB_FAIR_EN selects the arbitration policy:
//   - Defined: contended grants alternate between the two ports, starting with data.
//   - Undefined: data always wins over fetch.
module pipe_mem_arbiter (
    input  logic              clock,
    input  logic              reset,
    pipe_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY  = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic        m_req_q,    m_req_d;
    logic        m_we_q,     m_we_d;
    logic [31:0] m_addr_q,   m_addr_d;
    logic [31:0] m_wdata_q,  m_wdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q,  d_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q,  d_rdata_d;

    // High when the data port should win the grant this IDLE cycle.
    logic pick_data;

`ifdef PIPE_ARB_FAIR_EN
    // Remembers who won the last grant (1 = data). Reset value 0 lets data win
    // the first contended grant.
    logic last_d_q, last_d_d;

    assign pick_data = bus.d_req && !(bus.if_req && last_d_q);

    // Record the winner whenever a grant is issued.
    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (bus.d_req || bus.if_req)) begin
            last_d_d = pick_data;
        end
    end

    // Last-grant flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_data = bus.d_req;
`endif

    // Grant in IDLE, then wait for m_ack and turn it into a ready pulse.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Any m_ack seen here is stray and is ignored.
                if (pick_data) begin
                    state_d   = D_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end else if (bus.if_req) begin
                    // Fetches never write. Write data is left as-is because
                    // the memory does not use it for a read.
                    state_d  = IF_BUSY;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = bus.if_addr;
                end
            end
            IF_BUSY: begin
                if (bus.m_ack) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.m_rdata;
                end
            end
            D_BUSY: begin
                if (bus.m_ack) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    d_ready_d = 1'b1;
                    // A store leaves the previous load result in place.
                    if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter.
// The bench has three parts:
//   - Table-driven vectors for the basic fetch, store/load and contention cases.
//   - Hand-written slow-memory and reset-mid-access sequences.
//   - A randomized phase checked against a transaction-level model.
// Expected contention results follow PIPE_ARB_FAIR_EN when it is defined.
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;
`ifdef PIPE_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_mem_arbiter_if bus ();

    pipe_mem_arbiter dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0b want=%0b", name, act, exp);
        end
    endtask

    // Advance one clock. Outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_m_req"}, bus.m_req, 1'b0);
        check_bit({tag, "_m_we"}, bus.m_we, 1'b0);
        check32({tag, "_m_addr"}, bus.m_addr, 32'd0);
        check32({tag, "_m_wdata"}, bus.m_wdata, 32'd0);
        check_bit({tag, "_if_ready"}, bus.if_ready, 1'b0);
        check_bit({tag, "_d_ready"}, bus.d_ready, 1'b0);
        check32({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        check32({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
    endtask

    // Table vectors: inputs are applied for one cycle, and the outputs after
    // the following edge are compared.
    // chk bit 0: compare m_we and m_addr. chk bit 1: also compare m_wdata.
    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic        m_ack;
        logic [31:0] m_rdata;
        logic [1:0]  chk;
        logic        e_m_req, e_m_we;
        logic [31:0] e_m_addr, e_m_wdata;
        logic        e_if_ready, e_d_ready;
        logic [31:0] e_if_rdata, e_d_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic ifr, input logic [31:0] ifa,
        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic ack, input logic [31:0] rd, input logic [1:0] chk,
        input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
        input logic eifr, input logic edr, input logic [31:0] eifd, input logic [31:0] edd);
        vec_t v;
        v.rst = r;      v.if_req = ifr;  v.if_addr = ifa;
        v.d_req = dr;   v.d_we = dwe;    v.d_addr = da;   v.d_wdata = dwd;
        v.m_ack = ack;  v.m_rdata = rd;  v.chk = chk;
        v.e_m_req = emr; v.e_m_we = emw; v.e_m_addr = ema; v.e_m_wdata = emd;
        v.e_if_ready = eifr; v.e_d_ready = edr; v.e_if_rdata = eifd; v.e_d_rdata = edd;
        return v;
    endfunction

    // Randomized-phase state: reference model, requester agents, memory agent.
    logic [31:0] ref_mem   [8];
    logic [31:0] agent_mem [8];
    int          own;          // access in flight: 0 none, 1 fetch, 2 data
    logic        g_we;
    logic [31:0] g_addr, g_wdata;
    logic        last_data;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    logic        exp_mreq, exp_ifr, exp_dr, take_d;
    logic        p_ifreq, p_dreq, p_dwe, p_ack;
    logic [31:0] p_ifa, p_da, p_dwd;
    logic        f_pend, d_pend, d_we_r;
    logic [31:0] f_addr, d_addr_r, d_wdata_r;
    int          ack_cnt;
    logic        acked;
    int          ntx;

    function automatic int unsigned widx(input logic [31:0] a);
        return {29'd0, a[4:2]};
    endfunction

    initial begin
        rst = 1'b1;
        drive_idle();

        // ---- reset state ----
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // ---- table vectors ----
        // Fetch only: m_ack arrives in the first m_req cycle.
        tbl.push_back(mk(0,1,32'h40,0,0,0,0,0,0, 2'b01, 1,0,32'h40,0, 0,0,0,0));
        tbl.push_back(mk(0,1,32'h40,0,0,0,0,1,32'h8C220004, 2'b00, 0,0,0,0, 1,0,32'h8C220004,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0, 0,0,32'h8C220004,0));
        // Stray m_ack while idle.
        tbl.push_back(mk(0,0,0,0,0,0,0,1,32'hFFFFFFFF, 2'b00, 0,0,0,0, 0,0,32'h8C220004,0));
        // Store, then a load issued in the store's ready cycle.
        tbl.push_back(mk(0,0,0,1,1,32'h100,32'hDEADBEEF,0,0, 2'b11, 1,1,32'h100,32'hDEADBEEF, 0,0,32'h8C220004,0));
        tbl.push_back(mk(0,0,0,1,1,32'h100,32'hDEADBEEF,1,32'h55555555, 2'b00, 0,0,0,0, 0,1,32'h8C220004,0));
        tbl.push_back(mk(0,0,0,1,0,32'h100,0,0,0, 2'b01, 1,0,32'h100,0, 0,0,32'h8C220004,0));
        tbl.push_back(mk(0,0,0,1,0,32'h100,0,1,32'h12345678, 2'b00, 0,0,0,0, 0,1,32'h8C220004,32'h12345678));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0, 0,0,32'h8C220004,32'h12345678));
        // Reset clears everything, including the last-grant history.
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 2'b11, 0,0,0,0, 0,0,0,0));
        // Contention: both ports request continuously, and m_ack comes at once.
        tbl.push_back(mk(0,1,32'h300,1,0,32'h200,0,0,0, 2'b01, 1,0,32'h200,0, 0,0,0,0));
        tbl.push_back(mk(0,1,32'h300,1,0,32'h200,0,1,32'h11110001, 2'b00, 0,0,0,0, 0,1,0,32'h11110001));
        tbl.push_back(mk(0,1,32'h300,1,0,32'h200,0,0,0, 2'b01, 1,0,(FAIR ? 32'h300 : 32'h200),0,
                         0,0,0,32'h11110001));
        tbl.push_back(mk(0,1,32'h300,1,0,32'h200,0,1,32'h11110002, 2'b00, 0,0,0,0,
                         FAIR, !FAIR, (FAIR ? 32'h11110002 : 32'h0), (FAIR ? 32'h11110001 : 32'h11110002)));
        tbl.push_back(mk(0,1,32'h300,1,0,32'h200,0,0,0, 2'b01, 1,0,32'h200,0,
                         0,0,(FAIR ? 32'h11110002 : 32'h0),(FAIR ? 32'h11110001 : 32'h11110002)));
        tbl.push_back(mk(0,1,32'h300,1,0,32'h200,0,1,32'h11110003, 2'b00, 0,0,0,0,
                         0,1,(FAIR ? 32'h11110002 : 32'h0),32'h11110003));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,
                         0,0,(FAIR ? 32'h11110002 : 32'h0),32'h11110003));

        foreach (tbl[i]) begin
            rst         = tbl[i].rst;
            bus.if_req  = tbl[i].if_req;
            bus.if_addr = tbl[i].if_addr;
            bus.d_req   = tbl[i].d_req;
            bus.d_we    = tbl[i].d_we;
            bus.d_addr  = tbl[i].d_addr;
            bus.d_wdata = tbl[i].d_wdata;
            bus.m_ack   = tbl[i].m_ack;
            bus.m_rdata = tbl[i].m_rdata;
            tick();
            $display("vec %0d: m_req=%0b m_addr=%08h if_ready=%0b d_ready=%0b if_rdata=%08h d_rdata=%08h",
                     i, bus.m_req, bus.m_addr, bus.if_ready, bus.d_ready, bus.if_rdata, bus.d_rdata);
            check_bit($sformatf("vec%0d_m_req", i), bus.m_req, tbl[i].e_m_req);
            check_bit($sformatf("vec%0d_if_ready", i), bus.if_ready, tbl[i].e_if_ready);
            check_bit($sformatf("vec%0d_d_ready", i), bus.d_ready, tbl[i].e_d_ready);
            check32($sformatf("vec%0d_if_rdata", i), bus.if_rdata, tbl[i].e_if_rdata);
            check32($sformatf("vec%0d_d_rdata", i), bus.d_rdata, tbl[i].e_d_rdata);
            if (tbl[i].chk[0]) begin
                check_bit($sformatf("vec%0d_m_we", i), bus.m_we, tbl[i].e_m_we);
                check32($sformatf("vec%0d_m_addr", i), bus.m_addr, tbl[i].e_m_addr);
            end
            if (tbl[i].chk[1]) begin
                check32($sformatf("vec%0d_m_wdata", i), bus.m_wdata, tbl[i].e_m_wdata);
            end
        end
        rst = 1'b0;
        drive_idle();
        tick();

        // ---- slow memory: m_ack five cycles late, fetch request dropped early ----
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        tick();
        for (int k = 0; k < 6; k++) begin
            check_bit($sformatf("slow%0d_m_req", k), bus.m_req, 1'b1);
            check32($sformatf("slow%0d_m_addr", k), bus.m_addr, 32'h80);
            check_bit($sformatf("slow%0d_m_we", k), bus.m_we, 1'b0);
            check_bit($sformatf("slow%0d_if_ready", k), bus.if_ready, 1'b0);
            if (k >= 1) begin
                bus.if_req  = 1'b0;
                bus.if_addr = 32'hFFFF_FFF0;
            end
            bus.m_ack   = (k == 5);
            bus.m_rdata = (k == 5) ? 32'hA1B2C3D4 : 32'h0BAD0BAD;
            tick();
        end
        $display("slow: if_ready=%0b if_rdata=%08h", bus.if_ready, bus.if_rdata);
        check_bit("slow_if_ready", bus.if_ready, 1'b1);
        check32("slow_if_rdata", bus.if_rdata, 32'hA1B2C3D4);
        check_bit("slow_m_req_clear", bus.m_req, 1'b0);
        bus.m_ack = 1'b0;
        tick();
        check_bit("slow_if_ready_single", bus.if_ready, 1'b0);

        // ---- reset during a data access, then a late m_ack ----
        drive_idle();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h104;
        tick();
        check_bit("rstmid_m_req", bus.m_req, 1'b1);
        check32("rstmid_m_addr", bus.m_addr, 32'h104);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.d_req   = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h00000077;
        check_all_zero("rstmid");
        tick();
        check_bit("rstmid_no_d_ready", bus.d_ready, 1'b0);
        check32("rstmid_d_rdata", bus.d_rdata, 32'd0);
        check_bit("rstmid_m_req_idle", bus.m_req, 1'b0);
        // A fresh fetch must be granted at once, which shows the arbiter is back in IDLE.
        bus.m_ack   = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        tick();
        check_bit("rstmid_new_m_req", bus.m_req, 1'b1);
        check32("rstmid_new_m_addr", bus.m_addr, 32'h44);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h0000CAFE;
        tick();
        check_bit("rstmid_new_if_ready", bus.if_ready, 1'b1);
        check32("rstmid_new_if_rdata", bus.if_rdata, 32'h0000CAFE);
        $display("rstmid: new fetch done if_rdata=%08h", bus.if_rdata);

        // ---- randomized traffic against the transaction-level model ----
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i]   = 32'hC0DE0000 + i;
            agent_mem[i] = 32'hC0DE0000 + i;
        end
        own = 0; last_data = 1'b0; exp_if_rdata = 32'd0; exp_d_rdata = 32'd0;
        f_pend = 1'b0; d_pend = 1'b0; f_addr = 32'd0; d_addr_r = 32'd0; d_wdata_r = 32'd0; d_we_r = 1'b0;
        g_we = 1'b0; g_addr = 32'd0; g_wdata = 32'd0;
        ack_cnt = 0; acked = 1'b0; ntx = 0;
        p_ifreq = 1'b0; p_dreq = 1'b0; p_dwe = 1'b0; p_ack = 1'b0;
        p_ifa = 32'd0; p_da = 32'd0; p_dwd = 32'd0;
        tick();

        for (int cyc = 0; cyc < 2500; cyc++) begin
            // Model: what the inputs of the previous cycle should have produced.
            exp_ifr = 1'b0;
            exp_dr = 1'b0;
            exp_mreq = 1'b0;
            if (own != 0 && p_ack) begin
                if (own == 1) begin
                    exp_ifr = 1'b1;
                    exp_if_rdata = ref_mem[widx(g_addr)];
                end else begin
                    exp_dr = 1'b1;
                    if (g_we) ref_mem[widx(g_addr)] = g_wdata;
                    else      exp_d_rdata = ref_mem[widx(g_addr)];
                end
                ntx++;
                $display("txn %0d: port=%s we=%0b addr=%08h data=%08h", ntx, (own == 1) ? "F" : "D",
                         g_we, g_addr, g_we ? g_wdata : ref_mem[widx(g_addr)]);
                own = 0;
            end else if (own != 0) begin
                exp_mreq = 1'b1;
            end else if (p_ifreq || p_dreq) begin
                take_d = p_dreq && !(FAIR && p_ifreq && last_data);
                if (take_d) begin
                    own = 2; g_we = p_dwe; g_addr = p_da; g_wdata = p_dwd;
                end else begin
                    own = 1; g_we = 1'b0; g_addr = p_ifa; g_wdata = 32'd0;
                end
                last_data = take_d;
                exp_mreq = 1'b1;
            end

            check_bit("rnd_m_req", bus.m_req, exp_mreq);
            check_bit("rnd_if_ready", bus.if_ready, exp_ifr);
            check_bit("rnd_d_ready", bus.d_ready, exp_dr);
            check32("rnd_if_rdata", bus.if_rdata, exp_if_rdata);
            check32("rnd_d_rdata", bus.d_rdata, exp_d_rdata);
            if (exp_mreq) begin
                check32("rnd_m_addr", bus.m_addr, g_addr);
                check_bit("rnd_m_we", bus.m_we, g_we);
                if (g_we) check32("rnd_m_wdata", bus.m_wdata, g_wdata);
            end

            // Requesters: each holds its request until ready, then may issue
            // the next one in the ready cycle itself.
            if (exp_ifr) f_pend = 1'b0;
            if (exp_dr)  d_pend = 1'b0;
            if (!f_pend && $urandom_range(0, 3) != 0) begin
                f_pend = 1'b1;
                f_addr = 32'h100 + ($urandom_range(0, 7) << 2);
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend    = 1'b1;
                d_we_r    = 1'($urandom_range(0, 1));
                d_addr_r  = 32'h100 + ($urandom_range(0, 7) << 2);
                d_wdata_r = $urandom;
            end
            // A granted requester may drop its request or scramble its fields.
            if (own == 1 && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b0;
                bus.if_addr = $urandom;
            end else begin
                bus.if_req  = f_pend;
                bus.if_addr = f_addr;
            end
            if (own == 2 && $urandom_range(0, 2) == 0) begin
                bus.d_req   = 1'b0;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end else begin
                bus.d_req   = d_pend;
                bus.d_we    = d_we_r;
                bus.d_addr  = d_addr_r;
                bus.d_wdata = d_wdata_r;
            end

            // Memory agent: random acknowledge delay and occasional stray m_ack while idle.
            bus.m_ack   = 1'b0;
            bus.m_rdata = $urandom;
            if (bus.m_req) begin
                if (!acked) begin
                    if (ack_cnt == 0) begin
                        bus.m_ack = 1'b1;
                        acked = 1'b1;
                        if (bus.m_we) agent_mem[widx(bus.m_addr)] = bus.m_wdata;
                        else          bus.m_rdata = agent_mem[widx(bus.m_addr)];
                    end else begin
                        ack_cnt--;
                    end
                end
            end else begin
                acked = 1'b0;
                ack_cnt = int'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) bus.m_ack = 1'b1;
            end

            p_ifreq = bus.if_req; p_ifa = bus.if_addr;
            p_dreq = bus.d_req; p_dwe = bus.d_we; p_da = bus.d_addr; p_dwd = bus.d_wdata;
            p_ack = bus.m_ack;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
